// File: rtl/uart_pkg.sv
// Shared constants for the UART command responder: FSM state encodings,
// command opcodes and response bytes.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_ADDR = 3'd1;
  localparam state_t S_DATA = 3'd2;
  localparam state_t S_CSUM = 3'd3;
  localparam state_t S_BUS  = 3'd4;
  localparam state_t S_RSP  = 3'd5;

  // Command opcodes and response bytes
  localparam logic [BYTE_W-1:0] CMD_WRITE    = 8'h57;  // 'W'
  localparam logic [BYTE_W-1:0] CMD_READ     = 8'h52;  // 'R'
  localparam logic [BYTE_W-1:0] RSP_ACK      = 8'h4B;  // 'K'
  localparam logic [BYTE_W-1:0] RSP_NAK      = 8'h3F;  // '?'
  localparam logic [BYTE_W-1:0] RSP_CSUM_ERR = 8'h45;  // 'E'

endpackage

// File: rtl/uart_cmd_responder.sv
// UART command responder: parses 'W' addr data [csum] and 'R' addr byte
// commands from a UART receiver, performs a single register bus access and
// returns a one-byte response through the UART transmitter.
//
// Build option: define UART_RESP_CSUM_EN to require a fourth checksum byte
// (CMD_WRITE ^ addr ^ data) on write commands.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   rx_data/rx_valid       received byte + one-cycle valid pulse
//   tx_data/tx_valid       response byte + one-cycle transmit request
//   tx_ready               transmitter idle
//   reg_addr/reg_wdata     register address / write data (held between commands)
//   reg_we/reg_re          one-cycle write / read strobes
//   reg_rdata              read data, valid the cycle after reg_re
//   err_timeout            pulse when a command is aborted on inter-byte timeout
//   err_overrun            pulse (same cycle) when a byte arrives while busy
module uart_cmd_responder
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 1000000,
  parameter int unsigned REG_ADDR_W   = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [BYTE_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic [BYTE_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [BYTE_W-1:0]     reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [BYTE_W-1:0]     reg_rdata,
  output logic                  err_timeout,
  output logic                  err_overrun
);

  localparam int unsigned CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  state_t                  state_q, state_d;
  logic                    is_wr_q, is_wr_d;
  logic                    ph_q, ph_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0]       tx_data_d;
  logic                    tx_valid_d;
  logic [REG_ADDR_W-1:0]   reg_addr_d;
  logic [BYTE_W-1:0]       reg_wdata_d;
  logic                    reg_we_d, reg_re_d, err_timeout_d;
  logic                    in_cmd;

  // Bytes arriving while the bus access or response is pending are dropped
  assign err_overrun = rx_valid && ((state_q == S_BUS) || (state_q == S_RSP));

  assign in_cmd = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CSUM);

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      ph_q        <= 1'b0;
      cnt_q       <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      tx_data     <= tx_data_d;
      tx_valid    <= tx_valid_d;
      reg_addr    <= reg_addr_d;
      reg_wdata   <= reg_wdata_d;
      reg_we      <= reg_we_d;
      reg_re      <= reg_re_d;
      err_timeout <= err_timeout_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    is_wr_d       = is_wr_q;
    ph_d          = ph_q;
    cnt_d         = '0;
    tx_data_d     = tx_data;
    tx_valid_d    = 1'b0;
    reg_addr_d    = reg_addr;
    reg_wdata_d   = reg_wdata;
    reg_we_d      = 1'b0;
    reg_re_d      = 1'b0;
    err_timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE) begin
            is_wr_d = 1'b1;
            state_d = S_ADDR;
          end else if (rx_data == CMD_READ) begin
            is_wr_d = 1'b0;
            state_d = S_ADDR;
          end else begin
            tx_data_d = RSP_NAK;
            state_d   = S_RSP;
          end
        end
      end
      // Strobes are issued on the edge that accepts the final byte so the
      // strobe cycle coincides with the first S_BUS cycle.
      S_ADDR: begin
        if (rx_valid) begin
          reg_addr_d = REG_ADDR_W'(rx_data);
          if (is_wr_q) begin
            state_d = S_DATA;
          end else begin
            reg_re_d = 1'b1;
            ph_d     = 1'b0;
            state_d  = S_BUS;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          reg_wdata_d = rx_data;
`ifdef UART_RESP_CSUM_EN
          state_d = S_CSUM;
`else
          reg_we_d = 1'b1;
          state_d  = S_BUS;
`endif
        end
      end
`ifdef UART_RESP_CSUM_EN
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == (CMD_WRITE ^ BYTE_W'(reg_addr) ^ reg_wdata)) begin
            reg_we_d = 1'b1;
            state_d  = S_BUS;
          end else begin
            tx_data_d = RSP_CSUM_ERR;
            state_d   = S_RSP;
          end
        end
      end
`endif
      // Read: wait out the strobe cycle, then capture reg_rdata
      S_BUS: begin
        if (is_wr_q) begin
          tx_data_d = RSP_ACK;
          state_d   = S_RSP;
        end else if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d      = 1'b0;
          tx_data_d = reg_rdata;
          state_d   = S_RSP;
        end
      end
      S_RSP: begin
        if (tx_ready) begin
          tx_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout; an arriving byte always wins over expiry
    if (in_cmd && !rx_valid) begin
      if (cnt_q == TMO_LAST) begin
        state_d       = S_IDLE;
        err_timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed testbench for uart_cmd_responder. Honours UART_RESP_CSUM_EN the
// same way the design does (extra checksum byte on writes, checksum tests).
module tb_uart_cmd_responder;

  localparam int unsigned TMO = 16;

  logic       clk;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       err_timeout;
  logic       err_overrun;

  uart_cmd_responder #(.TIMEOUT_CLKS(TMO), .REG_ADDR_W(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitor and register-file read model
  int cyc = 0;
  int n_we = 0, n_re = 0, n_tx = 0, n_tmo = 0, n_ovr = 0;
  int rx_cyc = 0, we_cyc = 0, re_cyc = 0, tx_cyc = 0, tmo_cyc = 0;
  logic [7:0] we_addr = 8'h00, we_data = 8'h00, tx_byte = 8'h00;
  logic [7:0] rd_val = 8'h00;

  always @(posedge clk) begin
    if (rx_valid)    rx_cyc = cyc;
    if (reg_we)      begin n_we++; we_cyc = cyc; we_addr = reg_addr; we_data = reg_wdata; end
    if (reg_re)      begin n_re++; re_cyc = cyc; end
    if (tx_valid)    begin n_tx++; tx_cyc = cyc; tx_byte = tx_data; end
    if (err_timeout) begin n_tmo++; tmo_cyc = cyc; end
    if (err_overrun) n_ovr++;
    reg_rdata <= reg_re ? rd_val : 8'h00;
    cyc++;
  end

  int b_we, b_re, b_tx, b_tmo, b_ovr;

  task automatic snap();
    b_we = n_we; b_re = n_re; b_tx = n_tx; b_tmo = n_tmo; b_ovr = n_ovr;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic write_cmd(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'h57);
    send_byte(a);
    send_byte(d);
`ifdef UART_RESP_CSUM_EN
    send_byte(8'h57 ^ a ^ d);
`endif
  endtask

  initial begin
    resetn   = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    wait_cyc(3);

    // Reset state
    chk("rst_tx_data",   32'(tx_data), 32'h00);
    chk("rst_tx_valid",  32'(tx_valid), 32'h0);
    chk("rst_reg_addr",  32'(reg_addr), 32'h00);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'h00);
    chk("rst_reg_we",    32'(reg_we), 32'h0);
    chk("rst_reg_re",    32'(reg_re), 32'h0);
    chk("rst_err_tmo",   32'(err_timeout), 32'h0);
    chk("rst_err_ovr",   32'(err_overrun), 32'h0);
    resetn = 1'b1;
    wait_cyc(2);

    // Write 0x10 <= 0xA5
    snap();
    write_cmd(8'h10, 8'hA5);
    wait_cyc(10);
    chk("wr_we_count", 32'(n_we - b_we), 32'd1);
    chk("wr_addr",     32'(we_addr), 32'h10);
    chk("wr_data",     32'(we_data), 32'hA5);
    chk("wr_we_lat",   32'(we_cyc - rx_cyc), 32'd1);
    chk("wr_re_count", 32'(n_re - b_re), 32'd0);
    chk("wr_tx_count", 32'(n_tx - b_tx), 32'd1);
    chk("wr_rsp",      32'(tx_byte), 32'h4B);

    // Read 0x10 -> 0x3C
    rd_val = 8'h3C;
    snap();
    send_byte(8'h52);
    send_byte(8'h10);
    wait_cyc(10);
    chk("rd_re_count", 32'(n_re - b_re), 32'd1);
    chk("rd_re_lat",   32'(re_cyc - rx_cyc), 32'd1);
    chk("rd_we_count", 32'(n_we - b_we), 32'd0);
    chk("rd_tx_count", 32'(n_tx - b_tx), 32'd1);
    chk("rd_rsp",      32'(tx_byte), 32'h3C);
    chk("rd_tx_lat",   32'((tx_cyc - re_cyc) >= 2), 32'd1);

    // Unknown command byte
    snap();
    send_byte(8'h00);
    wait_cyc(6);
    chk("nak_we_count", 32'(n_we - b_we), 32'd0);
    chk("nak_re_count", 32'(n_re - b_re), 32'd0);
    chk("nak_tx_count", 32'(n_tx - b_tx), 32'd1);
    chk("nak_rsp",      32'(tx_byte), 32'h3F);
    chk("hold_addr",    32'(reg_addr), 32'h10);
    chk("hold_wdata",   32'(reg_wdata), 32'hA5);

    // Inter-byte timeout after 'W'
    snap();
    send_byte(8'h57);
    wait_cyc(30);
    chk("tmo_count",    32'(n_tmo - b_tmo), 32'd1);
    chk("tmo_lat",      32'(tmo_cyc - rx_cyc), 32'(TMO + 1));
    chk("tmo_tx_count", 32'(n_tx - b_tx), 32'd0);
    chk("tmo_we_count", 32'(n_we - b_we), 32'd0);
    rd_val = 8'h99;
    snap();
    send_byte(8'h52);
    send_byte(8'h01);
    wait_cyc(10);
    chk("post_tmo_re",   32'(n_re - b_re), 32'd1);
    chk("post_tmo_tx",   32'(n_tx - b_tx), 32'd1);
    chk("post_tmo_rsp",  32'(tx_byte), 32'h99);
    chk("post_tmo_addr", 32'(reg_addr), 32'h01);

    // Each byte lands on the very cycle the timeout would expire
    snap();
    send_byte(8'h57);
    wait_cyc(TMO - 2);
    send_byte(8'h11);
    wait_cyc(TMO - 2);
    send_byte(8'h5A);
`ifdef UART_RESP_CSUM_EN
    wait_cyc(TMO - 2);
    send_byte(8'h57 ^ 8'h11 ^ 8'h5A);
`endif
    wait_cyc(10);
    chk("edge_tmo_count", 32'(n_tmo - b_tmo), 32'd0);
    chk("edge_we_count",  32'(n_we - b_we), 32'd1);
    chk("edge_wr_addr",   32'(we_addr), 32'h11);
    chk("edge_wr_data",   32'(we_data), 32'h5A);
    chk("edge_rsp",       32'(tx_byte), 32'h4B);

    // Overrun while waiting in S_RSP with transmitter busy
    tx_ready = 1'b0;
    snap();
    send_byte(8'h00);
    wait_cyc(3);
    send_byte(8'h55);
    wait_cyc(100);
    chk("ovr_rsp_count", 32'(n_ovr - b_ovr), 32'd1);
    chk("ovr_tx_held",   32'(n_tx - b_tx), 32'd0);
    tx_ready = 1'b1;
    wait_cyc(5);
    chk("ovr_tx_count",  32'(n_tx - b_tx), 32'd1);
    chk("ovr_rsp",       32'(tx_byte), 32'h3F);
    chk("ovr_no_access", 32'((n_we - b_we) + (n_re - b_re)), 32'd0);

    // Overrun while the read bus access is in progress
    rd_val = 8'h6E;
    snap();
    send_byte(8'h52);
    send_byte(8'h20);
    send_byte(8'h57);
    wait_cyc(10);
    chk("ovr_bus_count", 32'(n_ovr - b_ovr), 32'd1);
    chk("ovr_bus_re",    32'(n_re - b_re), 32'd1);
    chk("ovr_bus_tx",    32'(n_tx - b_tx), 32'd1);
    chk("ovr_bus_rsp",   32'(tx_byte), 32'h6E);
    chk("ovr_bus_tmo",   32'(n_tmo - b_tmo), 32'd0);

    // Reset in the middle of a write command
    snap();
    send_byte(8'h57);
    send_byte(8'h33);
    resetn = 1'b0;
    wait_cyc(2);
    resetn = 1'b1;
    wait_cyc(30);
    chk("midrst_we",   32'(n_we - b_we), 32'd0);
    chk("midrst_tx",   32'(n_tx - b_tx), 32'd0);
    chk("midrst_tmo",  32'(n_tmo - b_tmo), 32'd0);
    chk("midrst_addr", 32'(reg_addr), 32'h00);

`ifdef UART_RESP_CSUM_EN
    // Bad checksum is rejected without a write
    snap();
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'hA5);
    send_byte(8'h00);
    wait_cyc(10);
    chk("csum_bad_we",  32'(n_we - b_we), 32'd0);
    chk("csum_bad_tx",  32'(n_tx - b_tx), 32'd1);
    chk("csum_bad_rsp", 32'(tx_byte), 32'h45);
    snap();
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'hA5);
    send_byte(8'hE2);
    wait_cyc(10);
    chk("csum_ok_we",   32'(n_we - b_we), 32'd1);
    chk("csum_ok_rsp",  32'(tx_byte), 32'h4B);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
